// File: rtl/iomem_pkg.sv
// Shared definitions for the iomem peripheral blocks: timer register offsets,
// CTRL bit positions and the byte-lane write merge used by every register block.
package iomem_pkg;

  typedef logic [1:0] reg_off_t;

  localparam reg_off_t TMR_CTRL   = 2'd0;
  localparam reg_off_t TMR_LOAD   = 2'd1;
  localparam reg_off_t TMR_COUNT  = 2'd2;
  localparam reg_off_t TMR_STATUS = 2'd3;

  localparam int unsigned EN     = 0;
  localparam int unsigned RELOAD = 1;
  localparam int unsigned IRQEN  = 2;
  localparam int unsigned CTRL_W = 3;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wstrb);
    logic [31:0] merged;
    merged = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every PRESCALE enabled cycles.
// The counter is held at zero whenever en is low.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;
  logic            w_wrap;

  always_comb begin
    w_wrap  = (r_cnt == CntMax);
    w_cnt_d = r_cnt;
    if (!i_en) begin
      w_cnt_d = '0;
    end else if (w_wrap) begin
      w_cnt_d = '0;
    end else begin
      w_cnt_d = r_cnt + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign o_tick = i_en && w_wrap;

endmodule

// File: rtl/iomem_timer.sv
// Memory-mapped countdown timer on the iomem bus: CTRL/LOAD/COUNT/STATUS
// registers, one-cycle ready handshake and a level interrupt on expiry.
module iomem_timer
  import iomem_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR = 8'h04,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_iomem_valid,
  input  logic [3:0]  i_iomem_wstrb,
  input  logic [31:0] i_iomem_addr,
  input  logic [31:0] i_iomem_wdata,
  output logic        o_iomem_ready,
  output logic [31:0] o_iomem_rdata,
  output logic        o_irq
);

  logic              r_ready;
  logic [31:0]       r_rdata;
  logic [CTRL_W-1:0] r_ctrl;
  logic [31:0]       r_load;
  logic [31:0]       r_count;
  logic              r_expired;

  logic              w_ready_d;
  logic [31:0]       w_rdata_d;
  logic [CTRL_W-1:0] w_ctrl_d;
  logic [31:0]       w_load_d;
  logic [31:0]       w_count_d;
  logic              w_expired_d;

  logic              w_sel;
  logic              w_wr;
  reg_off_t          w_off;
  logic [31:0]       w_rd_val;
  logic [31:0]       w_ctrl_merged;
  logic              w_count_wr;
  logic              w_status_clr;
  logic              w_expire;
  logic              w_tick;
  logic              w_unused_bits;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .resetn(resetn),
    .i_en  (r_ctrl[EN]),
    .o_tick(w_tick)
  );

  // Address bits [23:4] are don't-care so the four registers alias across the window.
  assign w_unused_bits = ^{i_iomem_addr[23:4], i_iomem_addr[1:0], w_ctrl_merged[31:CTRL_W]};

  always_comb begin
    w_sel = i_iomem_valid && !r_ready && (i_iomem_addr[31:24] == BASE_ADDR);
    w_off = i_iomem_addr[3:2];
    w_wr  = w_sel && (i_iomem_wstrb != 4'b0000);

    w_rd_val = '0;
    unique case (w_off)
      TMR_CTRL:   w_rd_val = {{(32-CTRL_W){1'b0}}, r_ctrl};
      TMR_LOAD:   w_rd_val = r_load;
      TMR_COUNT:  w_rd_val = r_count;
      TMR_STATUS: w_rd_val = {31'd0, r_expired};
      default:    w_rd_val = '0;
    endcase
  end

  always_comb begin
    w_ctrl_merged = strb_merge({{(32-CTRL_W){1'b0}}, r_ctrl}, i_iomem_wdata, i_iomem_wstrb);
    w_ctrl_d      = r_ctrl;
    if (w_wr && (w_off == TMR_CTRL)) w_ctrl_d = w_ctrl_merged[CTRL_W-1:0];

    w_load_d = r_load;
    if (w_wr && (w_off == TMR_LOAD)) w_load_d = strb_merge(r_load, i_iomem_wdata, i_iomem_wstrb);
  end

  // A bus write to COUNT replaces the whole tick evaluation for that cycle.
  always_comb begin
    w_count_wr = w_wr && (w_off == TMR_COUNT);
    w_expire   = w_tick && !w_count_wr && (r_count == 32'd1);
    w_count_d  = r_count;
    if (w_count_wr) begin
      w_count_d = strb_merge(r_count, i_iomem_wdata, i_iomem_wstrb);
    end else if (w_tick) begin
      if (r_count > 32'd1) begin
        w_count_d = r_count - 32'd1;
      end else if (r_count == 32'd1) begin
        w_count_d = r_ctrl[RELOAD] ? r_load : 32'd0;
      end
    end
  end

  // Expiry set has priority over a same-cycle W1C.
  always_comb begin
    w_status_clr = w_wr && (w_off == TMR_STATUS) && i_iomem_wstrb[0] && i_iomem_wdata[0];
    w_expired_d  = (r_expired && !w_status_clr) || w_expire;
    w_ready_d    = w_sel;
    w_rdata_d    = w_sel ? w_rd_val : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ready   <= 1'b0;
      r_rdata   <= '0;
      r_ctrl    <= '0;
      r_load    <= '0;
      r_count   <= '0;
      r_expired <= 1'b0;
    end else begin
      r_ready   <= w_ready_d;
      r_rdata   <= w_rdata_d;
      r_ctrl    <= w_ctrl_d;
      r_load    <= w_load_d;
      r_count   <= w_count_d;
      r_expired <= w_expired_d;
    end
  end

  assign o_iomem_ready = r_ready;
  assign o_iomem_rdata = r_rdata;
  assign o_irq         = r_expired && r_ctrl[IRQEN];

endmodule

// File: tb/tb_iomem_timer.sv
// Bench for iomem_timer: two instances (PRESCALE 1 and 4) on one shared bus,
// compared every cycle against a behavioural model, plus directed scenarios.
module tb_iomem_timer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid = 1'b0;
  logic [3:0]  wstrb = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;

  logic [1:0]  dut_ready;
  logic [1:0]  dut_irq;
  logic [31:0] dut_rdata [2];

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  logic [1:0]  last_rdy;
  logic [31:0] last_rd [2];

  // Model state, one slot per instance.
  int unsigned m_p [2] = '{1, 4};
  logic [2:0]  m_ctrl  [2];
  logic [31:0] m_load  [2];
  logic [31:0] m_count [2];
  logic        m_exp   [2];
  int unsigned m_phase [2];
  logic        m_ready [2];
  logic [31:0] m_rdata [2];

  localparam logic [31:0] A_CTRL   = 32'h0400_0000;
  localparam logic [31:0] A_LOAD   = 32'h0400_0004;
  localparam logic [31:0] A_COUNT  = 32'h0400_0008;
  localparam logic [31:0] A_STATUS = 32'h0400_000C;

  iomem_timer #(.BASE_ADDR(8'h04), .PRESCALE(1)) u_dut_p1 (
    .clk          (clk),
    .resetn       (resetn),
    .i_iomem_valid(valid),
    .i_iomem_wstrb(wstrb),
    .i_iomem_addr (addr),
    .i_iomem_wdata(wdata),
    .o_iomem_ready(dut_ready[0]),
    .o_iomem_rdata(dut_rdata[0]),
    .o_irq        (dut_irq[0])
  );

  iomem_timer #(.BASE_ADDR(8'h04), .PRESCALE(4)) u_dut_p4 (
    .clk          (clk),
    .resetn       (resetn),
    .i_iomem_valid(valid),
    .i_iomem_wstrb(wstrb),
    .i_iomem_addr (addr),
    .i_iomem_wdata(wdata),
    .o_iomem_ready(dut_ready[1]),
    .o_iomem_rdata(dut_rdata[1]),
    .o_irq        (dut_irq[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  task automatic model_step(input int m);
    logic        sel, wr, tick, set, clr;
    logic [1:0]  off;
    logic [31:0] rd, nxt_count, tmp;
    if (!resetn) begin
      m_ctrl[m] = 3'd0; m_load[m] = 32'd0; m_count[m] = 32'd0; m_exp[m] = 1'b0;
      m_phase[m] = 0; m_ready[m] = 1'b0; m_rdata[m] = 32'd0;
      return;
    end
    sel  = valid && !m_ready[m] && (addr[31:24] == 8'h04);
    off  = addr[3:2];
    wr   = sel && (wstrb != 4'd0);
    tick = m_ctrl[m][0] && (m_phase[m] == m_p[m] - 1);
    case (off)
      2'd0:    rd = {29'd0, m_ctrl[m]};
      2'd1:    rd = m_load[m];
      2'd2:    rd = m_count[m];
      default: rd = {31'd0, m_exp[m]};
    endcase
    m_phase[m] = m_ctrl[m][0] ? (m_phase[m] + 1) % m_p[m] : 0;
    set = 1'b0;
    nxt_count = m_count[m];
    if (wr && off == 2'd2) begin
      nxt_count = lanes(m_count[m], wdata, wstrb);
    end else if (tick && m_count[m] != 0) begin
      if (m_count[m] == 1) begin
        set = 1'b1;
        nxt_count = m_ctrl[m][1] ? m_load[m] : 32'd0;
      end else begin
        nxt_count = m_count[m] - 1;
      end
    end
    clr = wr && off == 2'd3 && wstrb[0] && wdata[0];
    if (clr) m_exp[m] = 1'b0;
    if (set) m_exp[m] = 1'b1;
    if (wr && off == 2'd0) begin
      tmp = lanes({29'd0, m_ctrl[m]}, wdata, wstrb);
      m_ctrl[m] = tmp[2:0];
    end
    if (wr && off == 2'd1) m_load[m] = lanes(m_load[m], wdata, wstrb);
    m_count[m] = nxt_count;
    m_ready[m] = sel;
    m_rdata[m] = sel ? rd : 32'd0;
  endtask

  always @(posedge clk) for (int m = 0; m < 2; m++) model_step(m);

  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        check($sformatf("ready_p%0d", m_p[m]), 32'(dut_ready[m]), 32'(m_ready[m]));
        check($sformatf("rdata_p%0d", m_p[m]), dut_rdata[m], m_rdata[m]);
        check($sformatf("irq_p%0d", m_p[m]), 32'(dut_irq[m]), 32'(m_exp[m] & m_ctrl[m][2]));
      end
    end
  end

  // Called at a negedge; returns at a negedge one idle cycle after the response.
  task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    valid = 1'b1; addr = a; wstrb = s; wdata = d;
    @(negedge clk);
    last_rdy   = dut_ready;
    last_rd[0] = dut_rdata[0];
    last_rd[1] = dut_rdata[1];
    valid = 1'b0; wstrb = 4'd0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s, pat;

    repeat (2) @(negedge clk);
    resetn = 1'b1;
    chk_en = 1'b1;

    bus(A_COUNT, 4'd0, 32'd0);
    check("rst_ready", 32'(last_rdy), 32'd3);
    check("rst_rdata", last_rd[0], 32'd0);
    check("rst_irq", 32'(dut_irq), 32'd0);

    // One-shot on the PRESCALE=1 instance: expiry five ticks after enable.
    do_reset();
    bus(A_COUNT, 4'hF, 32'd5);
    bus(A_CTRL, 4'hF, 32'h5);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check("oneshot_irq", 32'(dut_irq[0]), 32'(k == 5));
    end
    bus(A_COUNT, 4'd0, 32'd0);
    check("oneshot_count", last_rd[0], 32'd0);
    bus(A_STATUS, 4'd0, 32'd0);
    check("oneshot_status", last_rd[0], 32'd1);

    // Auto-reload on the PRESCALE=4 instance: 12-cycle period.
    do_reset();
    bus(A_LOAD, 4'hF, 32'd3);
    bus(A_COUNT, 4'hF, 32'd3);
    bus(A_CTRL, 4'hF, 32'h7);
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      check("reload_irq1", 32'(dut_irq[1]), 32'(k == 12));
    end
    bus(A_STATUS, 4'h1, 32'd1);
    check("reload_clr", 32'(dut_irq[1]), 32'd0);
    for (int k = 15; k <= 24; k++) begin
      @(negedge clk);
      check("reload_irq2", 32'(dut_irq[1]), 32'(k == 24));
    end

    // W1C landing on the expiry cycle loses to the set.
    do_reset();
    bus(A_COUNT, 4'hF, 32'd4);
    bus(A_CTRL, 4'hF, 32'h5);
    @(negedge clk);
    @(negedge clk);
    bus(A_STATUS, 4'h1, 32'd1);
    bus(A_STATUS, 4'd0, 32'd0);
    check("setclr_status", last_rd[0], 32'd1);
    bus(A_STATUS, 4'h1, 32'd1);
    bus(A_STATUS, 4'd0, 32'd0);
    check("clr_status", last_rd[0], 32'd0);
    check("clr_irq", 32'(dut_irq[0]), 32'd0);

    // Byte strobes, decode miss and aliasing.
    do_reset();
    bus(A_LOAD, 4'b0101, 32'hAABB_CCDD);
    bus(A_LOAD, 4'd0, 32'd0);
    check("strb_load", last_rd[0], 32'h00BB_00DD);
    check("strb_load_p4", last_rd[1], 32'h00BB_00DD);
    bus(32'h0300_0000, 4'd0, 32'd0);
    check("miss_ready", 32'(last_rdy), 32'd0);
    check("miss_rdata", last_rd[0], 32'd0);
    bus(32'h0300_0004, 4'hF, 32'h1111_1111);
    bus(32'h04FF_FFF4, 4'hF, 32'h1234_5678);
    bus(A_LOAD, 4'd0, 32'd0);
    check("alias_load", last_rd[0], 32'h1234_5678);

    // Held valid: served every other cycle.
    valid = 1'b1; addr = A_LOAD; wstrb = 4'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat[i] = dut_ready[0];
    end
    valid = 1'b0;
    @(negedge clk);
    check("b2b_pattern", 32'(pat), 32'h5);

    // Reset in the middle of a count.
    bus(A_COUNT, 4'hF, 32'd1000);
    bus(A_CTRL, 4'hF, 32'h1);
    repeat (3) @(negedge clk);
    do_reset();
    bus(A_COUNT, 4'd0, 32'd0);
    check("midrst_count", last_rd[0], 32'd0);
    bus(A_CTRL, 4'd0, 32'd0);
    check("midrst_ctrl", last_rd[0], 32'd0);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      a = {($urandom_range(0, 7) == 0) ? 8'h03 : 8'h04, 24'($urandom)};
      s = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
      if (a[3:2] == 2'd1 || a[3:2] == 2'd2) d = 32'($urandom_range(0, 12));
      else d = $urandom;
      bus(a, s, d);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/iomem_timer.md
Name: iomem_timer

Overview:
- Memory-mapped countdown timer peripheral on the SoC iomem bus, in parallel with the GPIO register block at top level.
- Decodes its own address window, answers with the same one-cycle ready handshake, and drives a level interrupt into one of the SoC irq inputs (irq_5).
- Gives firmware a periodic tick and timeout source.

Parameters:
- BASE_ADDR, 8'h04, value compared against iomem_addr[31:24] to select this block.
- PRESCALE, 1, clk cycles per timer tick; legal range 1..65536. A value of 1 ticks every cycle.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- iomem_valid  in  1  bus request valid
- iomem_wstrb  in  4  byte write strobes; 0 means read
- iomem_addr  in  32  byte address
- iomem_wdata  in  32  write data
- iomem_ready  out  1  one-cycle acknowledge
- iomem_rdata  out  32  read data; valid while ready=1, else 0
- irq  out  1  level interrupt = STATUS.expired & CTRL.irq_en

Behaviour:
- Reset (resetn=0 at posedge clk): ready=0, rdata=0, irq=0, CTRL=0, LOAD=0, COUNT=0, STATUS=0, prescaler=0.
- Address decode:
  - Select when iomem_addr[31:24]==BASE_ADDR.
  - Register offset is iomem_addr[3:2]; addr[23:4] is ignored, so the four registers alias across the window.
- Register map:
  - 0 CTRL: bit0 enable, bit1 auto_reload, bit2 irq_en; other bits read 0.
  - 1 LOAD: 32-bit reload value.
  - 2 COUNT: current count; a write loads the count directly.
  - 3 STATUS: bit0 expired, sticky; writing 1 to bit0 clears it.
- Handshake:
  - Default each cycle: ready<=0, rdata<=0.
  - If valid & !ready & selected: ready<=1 and rdata<=register value before the write.
  - The write is applied in that same cycle, per byte lane, under wstrb.
  - Latency is exactly 1 cycle. Back-to-back requests are served every other cycle.
  - Unselected requests get no response. rdata=0 when idle, so the top level may OR this block's rdata with other peripherals.
- Byte strobes apply to CTRL, LOAD and COUNT. STATUS acts only on bit0, and only when wstrb[0]=1.
- Prescaler:
  - While enable=0 the prescaler holds 0.
  - While enable=1 it counts 0..PRESCALE-1 and asserts tick for one cycle when it wraps.
  - PRESCALE=1 gives tick=1 on every enabled cycle.
- Count, evaluated on each tick:
  - COUNT>1: COUNT<=COUNT-1.
  - COUNT==1: expired<=1; COUNT<=auto_reload ? LOAD : 0.
  - COUNT==0: no change; the timer stays stopped in one-shot done.
  - Period with auto_reload is LOAD ticks.
  - LOAD=0 with auto_reload set: one expiry, then the timer stops at 0.
- Simultaneous events:
  - Bus write to COUNT on a tick cycle: the bus value wins and no decrement occurs that cycle.
  - W1C to STATUS on the cycle expiry is set: the set wins, and expired stays 1.
  - A write to CTRL.enable takes effect on the next cycle. Clearing enable zeroes the prescaler immediately.
- irq is combinational from registered bits, so it follows STATUS/CTRL with no extra delay.
- Reset mid-transaction: ready drops and all state clears. The master must re-issue the request.

Decomposition:
- Package iomem_pkg holds:
  - register offsets TMR_CTRL=2'd0, TMR_LOAD=2'd1, TMR_COUNT=2'd2, TMR_STATUS=2'd3;
  - CTRL bit indices EN=0, RELOAD=1, IRQEN=2;
  - a helper function for per-byte strobe merge, shared with the GPIO register block.
- Sub-module tick_prescaler:
  - parameter PRESCALE; ports clk, resetn, en, tick.
  - Counter width is $clog2(PRESCALE), minimum 1.

Test Plan:
- Read after reset: read addr 0x0400_0008 -> ready exactly 1 cycle after valid, rdata=0; irq=0.
- One-shot expiry, PRESCALE=1:
  - Stimulus: write COUNT=5, then CTRL=0x5.
  - Required: COUNT steps 4,3,2,1,0 on consecutive cycles; STATUS=1 and irq=1 on the cycle COUNT reaches 0; COUNT then stays 0.
- Auto-reload, PRESCALE=4:
  - Stimulus: LOAD=3, COUNT=3, CTRL=0x3.
  - Required: expired sets every 12 clk cycles; COUNT sequence 2,1,3,2,1,3.
- Byte strobes: write 0xAABBCCDD to LOAD with wstrb=4'b0101 over LOAD=0 -> read returns 0x00BB00DD.
- Simultaneous set/clear: issue W1C STATUS on the exact expiry cycle -> STATUS reads 1 afterwards; a second W1C -> STATUS=0, irq=0.
- Decode miss and alias:
  - Access at 0x0300_0000 -> no ready from this block, rdata=0.
  - Access at 0x04FF_FFF4 (offset 1) -> LOAD is accessed.
  - Reset asserted mid-count -> COUNT=0, CTRL=0 on the next cycle.
